// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states, byte-enable helpers.
package mem_pkg;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  localparam logic [3:0] DMEM_BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Size 11 has no meaning of its own and behaves as a word access.
  function automatic logic [1:0] mem_norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? MEM_SZ_WORD : sz;
  endfunction

  function automatic logic [3:0] mem_store_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      MEM_SZ_BYTE: be = 4'b0001 << lo;
      MEM_SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:     be = DMEM_BE_ALL;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus; master is the pipeline stage, slave is the memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load lane select plus zero/sign extension of a little-endian read word.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    result_o = rdata_i;
    case (mem_norm_size(size_i))
      MEM_SZ_BYTE: result_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      MEM_SZ_HALF: result_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      default:     result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: runs the dmem req/ack transaction, stalls the front end until DONE.
// Optional MEM_MISALIGN_TRAP_EN adds MEM_Misalign and suppresses misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic               MEM_WB_RegWre,
  input  logic [1:0]         MEM_Size,
  input  logic               MEM_Unsigned,
  input  logic [31:0]        MEM_ALU_Result,
  input  logic [31:0]        MEM_StoreData,
  input  logic [4:0]         MEM_Reg_RD,
  mem_access_unit_if.master  dmem,
  output logic               MEM_Stall,
  output logic               WB_RegWre_o,
  output logic [4:0]         WB_Reg_RD_o,
  output logic [31:0]        MEM_ALU_DataBus
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               MEM_Misalign
`endif
);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ld_q;
  logic [1:0]        lo_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic              access;
  logic              is_load;
  logic [1:0]        size_n;
  logic [1:0]        lo;
  logic              misalign;
  logic              go;
  logic              idle_req;
  logic              waiting;
  logic              req;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       load_ext;

  assign access  = MEM_MemRead | MEM_MemWrite;
  assign is_load = MEM_MemRead;
  assign size_n  = mem_norm_size(MEM_Size);
  assign lo      = MEM_ALU_Result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (state_q == ST_IDLE) &
                    (((size_n == MEM_SZ_HALF) & lo[0]) |
                     ((size_n == MEM_SZ_WORD) & (lo != 2'b00)));
  assign MEM_Misalign = ~RST & misalign;
`else
  assign misalign = 1'b0;
`endif

  assign go       = access & ~misalign;
  assign idle_req = (state_q == ST_IDLE) & go;
  assign waiting  = (state_q == ST_WAIT);
  assign req      = ~RST & (idle_req | waiting);

  // Memory is word addressed; the low bits only steer lanes.
  assign addr_d = {MEM_ALU_Result[ADDR_W-1:2], 2'b00};
  assign we_d   = ~is_load;
  assign be_d   = is_load ? DMEM_BE_ALL : mem_store_be(size_n, lo);

  always_comb begin
    wdata_d = MEM_StoreData;
    case (size_n)
      MEM_SZ_BYTE: wdata_d = {4{MEM_StoreData[7:0]}};
      MEM_SZ_HALF: wdata_d = {2{MEM_StoreData[15:0]}};
      default:     wdata_d = MEM_StoreData;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ld_q    <= 1'b0;
      lo_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= is_load;
            lo_q    <= lo;
            size_q  <= size_n;
            uns_q   <= MEM_Unsigned;
            if (dmem.ack) begin
              rdata_q <= dmem.rdata;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem.ack) begin
            rdata_q <= dmem.rdata;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_load_align u_align (
    .rdata_i    (rdata_q),
    .addr_lo_i  (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_ext)
  );

  // WAIT replays the captured request so the memory sees a stable bus.
  assign dmem.req   = req;
  assign dmem.we    = ~RST & (waiting ? we_q : (idle_req & we_d));
  assign dmem.be    = RST ? 4'b0000 : (waiting ? be_q : (idle_req ? be_d : 4'b0000));
  assign dmem.addr  = waiting ? addr_q : addr_d;
  assign dmem.wdata = waiting ? wdata_q : wdata_d;

  assign MEM_Stall       = req;
  assign WB_RegWre_o     = ~RST & MEM_WB_RegWre & ~req & ~misalign;
  assign WB_Reg_RD_o     = MEM_Reg_RD;
  assign MEM_ALU_DataBus = RST ? 32'h0 :
                           (((state_q == ST_DONE) & ld_q) ? load_ext : MEM_ALU_Result);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        CLK;
  logic        RST;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        MEM_WB_RegWre;
  logic [1:0]  MEM_Size;
  logic        MEM_Unsigned;
  logic [31:0] MEM_ALU_Result;
  logic [31:0] MEM_StoreData;
  logic [4:0]  MEM_Reg_RD;
  logic        MEM_Stall;
  logic        WB_RegWre_o;
  logic [4:0]  WB_Reg_RD_o;
  logic [31:0] MEM_ALU_DataBus;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MEM_Misalign;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  mem_access_unit_if #(.ADDR_W(32)) dmem_bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .MEM_MemRead     (MEM_MemRead),
    .MEM_MemWrite    (MEM_MemWrite),
    .MEM_WB_RegWre   (MEM_WB_RegWre),
    .MEM_Size        (MEM_Size),
    .MEM_Unsigned    (MEM_Unsigned),
    .MEM_ALU_Result  (MEM_ALU_Result),
    .MEM_StoreData   (MEM_StoreData),
    .MEM_Reg_RD      (MEM_Reg_RD),
    .dmem            (dmem_bus.master),
    .MEM_Stall       (MEM_Stall),
    .WB_RegWre_o     (WB_RegWre_o),
    .WB_Reg_RD_o     (WB_Reg_RD_o),
    .MEM_ALU_DataBus (MEM_ALU_DataBus)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .MEM_Misalign    (MEM_Misalign)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic rw, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] dst);
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_WB_RegWre  = rw;
    MEM_Size       = sz;
    MEM_Unsigned   = u;
    MEM_ALU_Result = a;
    MEM_StoreData  = sd;
    MEM_Reg_RD     = dst;
  endtask

  task automatic idle_instr();
    set_instr(1'b0, 1'b0, 1'b0, MEM_SZ_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
  endtask

  // Load answered in the request cycle: one stall cycle, result in DONE.
  task automatic zw_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] rdv, input logic [31:0] exp);
    logic [31:0] aligned;
    aligned = {a[31:2], 2'b00};
    set_instr(1'b1, 1'b0, 1'b1, sz, u, a, 32'h0, 5'd7);
    dmem_bus.rdata = rdv;
    dmem_bus.ack   = 1'b1;
    #2;
    chk({tag, "_req"},   dmem_bus.req, 1);
    chk({tag, "_we"},    dmem_bus.we, 0);
    chk({tag, "_be"},    dmem_bus.be, 4'b1111);
    chk({tag, "_addr"},  dmem_bus.addr, aligned);
    chk({tag, "_stall"}, MEM_Stall, 1);
    chk({tag, "_wbre"},  WB_RegWre_o, 0);
    tick();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    #2;
    chk({tag, "_done_stall"}, MEM_Stall, 0);
    chk({tag, "_done_wbre"},  WB_RegWre_o, 1);
    chk({tag, "_done_rd"},    WB_Reg_RD_o, 5'd7);
    chk({tag, "_data"},       MEM_ALU_DataBus, exp);
    tick();
    idle_instr();
  endtask

  task automatic zw_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] sd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_addr);
    set_instr(1'b0, 1'b1, 1'b0, sz, 1'b0, a, sd, 5'd0);
    dmem_bus.ack = 1'b1;
    #2;
    chk({tag, "_req"},   dmem_bus.req, 1);
    chk({tag, "_we"},    dmem_bus.we, 1);
    chk({tag, "_be"},    dmem_bus.be, exp_be);
    chk({tag, "_wdata"}, dmem_bus.wdata, exp_wd);
    chk({tag, "_addr"},  dmem_bus.addr, exp_addr);
    chk({tag, "_stall"}, MEM_Stall, 1);
    tick();
    dmem_bus.ack = 1'b0;
    #2;
    chk({tag, "_done_stall"}, MEM_Stall, 0);
    chk({tag, "_done_data"},  MEM_ALU_DataBus, a);
    tick();
    idle_instr();
  endtask

  initial begin
    int stall_cnt;
    RST = 1'b1;
    idle_instr();
    // Reset must mask an access that is already present.
    set_instr(1'b1, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd3);
    tick();
    #2;
    chk("rst_req",   dmem_bus.req, 0);
    chk("rst_we",    dmem_bus.we, 0);
    chk("rst_be",    dmem_bus.be, 0);
    chk("rst_stall", MEM_Stall, 0);
    chk("rst_wbre",  WB_RegWre_o, 0);
    chk("rst_data",  MEM_ALU_DataBus, 0);
    tick();
    RST = 1'b0;
    idle_instr();

    // Pass-through with no access.
    set_instr(1'b0, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h0000_1234, 32'h0, 5'd9);
    #2;
    chk("alu_pass_data",  MEM_ALU_DataBus, 32'h0000_1234);
    chk("alu_pass_stall", MEM_Stall, 0);
    chk("alu_pass_wbre",  WB_RegWre_o, 1);
    chk("alu_pass_req",   dmem_bus.req, 0);
    tick();
    idle_instr();

    zw_load("lw_zw",  32'h100, MEM_SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    zw_load("lb_sx",  32'h103, MEM_SZ_BYTE, 1'b0, 32'h8011_2233, 32'hFFFF_FF80);
    zw_load("lbu",    32'h103, MEM_SZ_BYTE, 1'b1, 32'h8011_2233, 32'h0000_0080);
    zw_load("lb_b1",  32'h101, MEM_SZ_BYTE, 1'b0, 32'h8011_2233, 32'h0000_0022);
    zw_load("lh_sx",  32'h102, MEM_SZ_HALF, 1'b0, 32'h8011_2233, 32'hFFFF_8011);
    zw_load("lhu_lo", 32'h100, MEM_SZ_HALF, 1'b1, 32'h8011_A233, 32'h0000_A233);
    zw_load("lw_sz3", 32'h104, 2'b11,       1'b0, 32'h8765_4321, 32'h8765_4321);

    zw_store("sh", 32'h102, MEM_SZ_HALF, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h100);
    zw_store("sb", 32'h101, MEM_SZ_BYTE, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A, 32'h100);
    zw_store("sw", 32'h208, MEM_SZ_WORD, 32'hCAFE_0001, 4'b1111, 32'hCAFE_0001, 32'h208);

    // Ack three cycles after the request: four stall cycles, bus held stable.
    stall_cnt = 0;
    set_instr(1'b1, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h200, 32'h0, 5'd4);
    dmem_bus.rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      dmem_bus.ack = (c == 3);
      #2;
      if (MEM_Stall === 1'b1) stall_cnt++;
      chk("lw_d3_req",  dmem_bus.req, 1);
      chk("lw_d3_addr", dmem_bus.addr, 32'h200);
      chk("lw_d3_be",   dmem_bus.be, 4'b1111);
      chk("lw_d3_wbre", WB_RegWre_o, 0);
      tick();
    end
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    #2;
    chk("lw_d3_stall_cycles", stall_cnt, 4);
    chk("lw_d3_done_stall",   MEM_Stall, 0);
    chk("lw_d3_done_wbre",    WB_RegWre_o, 1);
    chk("lw_d3_data",         MEM_ALU_DataBus, 32'h1234_5678);
    tick();
    idle_instr();

    // Reset while waiting; a late ack afterwards must be ignored.
    set_instr(1'b1, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h300, 32'h0, 5'd5);
    #2;
    chk("rw_req0", dmem_bus.req, 1);
    tick();
    #2;
    chk("rw_wait_req", dmem_bus.req, 1);
    RST = 1'b1;
    #1;
    chk("rw_rst_req",   dmem_bus.req, 0);
    chk("rw_rst_stall", MEM_Stall, 0);
    chk("rw_rst_wbre",  WB_RegWre_o, 0);
    tick();
    RST = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, MEM_SZ_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'hBAD0_BAD0;
    #2;
    chk("rw_late_req",  dmem_bus.req, 0);
    chk("rw_late_wbre", WB_RegWre_o, 0);
    chk("rw_late_data", MEM_ALU_DataBus, 32'h0);
    tick();
    idle_instr();
    // A fresh load proves the FSM is back in IDLE and not replaying 0x300.
    set_instr(1'b1, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h400, 32'h0, 5'd6);
    #2;
    chk("rw_new_addr",  dmem_bus.addr, 32'h400);
    chk("rw_new_stall", MEM_Stall, 1);
    tick();
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'hCAFE_F00D;
    tick();
    dmem_bus.ack = 1'b0;
    #2;
    chk("rw_new_data", MEM_ALU_DataBus, 32'hCAFE_F00D);
    chk("rw_new_wbre", WB_RegWre_o, 1);
    tick();
    idle_instr();

    // Ack with no access in IDLE is ignored.
    dmem_bus.ack = 1'b1;
    #2;
    chk("idle_ack_req",   dmem_bus.req, 0);
    chk("idle_ack_stall", MEM_Stall, 0);
    tick();
    idle_instr();

`ifdef MEM_MISALIGN_TRAP_EN
    set_instr(1'b1, 1'b0, 1'b1, MEM_SZ_WORD, 1'b0, 32'h102, 32'h0, 5'd8);
    dmem_bus.ack = 1'b0;
    #2;
    chk("mis_flag",  MEM_Misalign, 1);
    chk("mis_req",   dmem_bus.req, 0);
    chk("mis_stall", MEM_Stall, 0);
    chk("mis_wbre",  WB_RegWre_o, 0);
    tick();
    idle_instr();
    #2;
    chk("mis_clear", MEM_Misalign, 0);
`else
    zw_load("lw_mis", 32'h102, MEM_SZ_WORD, 1'b0, 32'h1122_3344, 32'h1122_3344);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
